hit_judge: RTL

//   Timing judge that sits directly upstream of the score recorder. It opens a
//   hit window when a note reaches the judgement line and measures the player's

---
 rtl/hit_judge.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/hit_judge.sv
// Rhythm-game hit judge: debounces the player button, times the press against
// the ideal hit instant of each note and emits one registered grade per note.
module hit_judge #(
  parameter int unsigned CENTER     = 100,
  parameter int unsigned GREAT_TOL  = 20,
  parameter int unsigned NICE_TOL   = 50,
  parameter int unsigned NORMAL_TOL = 80,
  parameter int unsigned DB_CYC     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       tick_en,
  input  logic       note_valid,
  input  logic       btn,
  output logic       judge_valid,
  output logic [1:0] judge_grade,
  output logic [7:0] combo
);

  localparam logic [15:0] CTR = 16'(CENTER);
  localparam logic [15:0] LIM = 16'(2 * CENTER);
  localparam logic [15:0] GT  = 16'(GREAT_TOL);
  localparam logic [15:0] NT  = 16'(NICE_TOL);
  localparam logic [15:0] OT  = 16'(NORMAL_TOL);
  localparam logic [7:0]  DBL = 8'(DB_CYC - 1);

  localparam logic [1:0] G_BAD    = 2'b00;
  localparam logic [1:0] G_NORMAL = 2'b01;
  localparam logic [1:0] G_NICE   = 2'b10;
  localparam logic [1:0] G_GREAT  = 2'b11;

  typedef enum logic {
    S_IDLE,
    S_WINDOW
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        s1_q, s2_q;
  logic        db_q, db_d;
  logic        dbp_q;
  logic [7:0]  dbc_q, dbc_d;
  logic        valid_q;
  logic [1:0]  grade_q;
  logic [7:0]  combo_q;
  logic        press;
  logic        res_v;
  logic [1:0]  res_g;

  function automatic logic [1:0] grade_f(input logic [15:0] c);
    logic [15:0] off;
    off = (c >= CTR) ? (c - CTR) : (CTR - c);
    if (off <= GT)      grade_f = G_GREAT;
    else if (off <= NT) grade_f = G_NICE;
    else if (off <= OT) grade_f = G_NORMAL;
    else                grade_f = G_BAD;
  endfunction

  // Level flips on the DB_CYC-th consecutive sample that disagrees with it.
  always_comb begin
    db_d  = db_q;
    dbc_d = 8'd0;
    if (s2_q != db_q) begin
      if (dbc_q >= DBL) begin
        db_d  = s2_q;
        dbc_d = 8'd0;
      end else begin
        dbc_d = dbc_q + 8'd1;
      end
    end
  end

  assign press = db_q & ~dbp_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_v   = 1'b0;
    res_g   = G_BAD;
    if (!run) begin
      state_d = S_IDLE;
      cnt_d   = 16'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (note_valid) begin
            cnt_d = 16'd0;
            if (press) begin
              res_v = 1'b1;
              res_g = grade_f(16'd0);
            end else begin
              state_d = S_WINDOW;
            end
          end
        end
        S_WINDOW: begin
          if (press) begin
            res_v = 1'b1;
            res_g = grade_f(cnt_q);
            cnt_d = 16'd0;
            if (!note_valid) state_d = S_IDLE;
          end else if (note_valid) begin
            res_v = 1'b1;
            res_g = G_BAD;
            cnt_d = 16'd0;
          end else if (tick_en) begin
            if (cnt_q >= LIM) begin
              res_v   = 1'b1;
              res_g   = G_BAD;
              cnt_d   = 16'd0;
              state_d = S_IDLE;
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 16'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      db_q    <= 1'b0;
      dbp_q   <= 1'b0;
      dbc_q   <= 8'd0;
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      valid_q <= 1'b0;
      grade_q <= G_BAD;
      combo_q <= 8'd0;
    end else begin
      s1_q    <= btn;
      s2_q    <= s1_q;
      db_q    <= db_d;
      dbp_q   <= db_q;
      dbc_q   <= dbc_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= res_v;
      if (res_v) begin
        grade_q <= res_g;
        if (res_g[1])
          combo_q <= (combo_q == 8'hFF) ? 8'hFF : combo_q + 8'd1;
        else
          combo_q <= 8'd0;
      end
    end
  end

  assign judge_valid = valid_q;
  assign judge_grade = grade_q;
  assign combo       = combo_q;

endmodule
